// File: rtl/idex_stage_pkg.sv
// Shared widths, ALU operation codes, forward-select encodings and the EX register layout
// for the ID/EX stage.
package idex_stage_pkg;

    localparam int DW  = 32;
    localparam int RW  = 5;
    localparam int OPW = 5;

    localparam logic [OPW-1:0] ALUOP_NOP  = 5'd0;
    localparam logic [OPW-1:0] ALUOP_LUI  = 5'd1;
    localparam logic [OPW-1:0] ALUOP_ADDU = 5'd2;
    localparam logic [OPW-1:0] ALUOP_SUBU = 5'd3;
    localparam logic [OPW-1:0] ALUOP_OR   = 5'd4;
    localparam logic [OPW-1:0] ALUOP_SLL  = 5'd5;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic           valid;
        logic           regwrite;
        logic           memread;
        logic           memwrite;
        logic           alusrc;
        logic [OPW-1:0] aluop;
        logic [RW-1:0]  rs;
        logic [RW-1:0]  rt;
        logic [RW-1:0]  wa;
        logic [DW-1:0]  pc;
        logic [DW-1:0]  rd1;
        logic [DW-1:0]  rd2;
        logic [DW-1:0]  imm;
    } ex_reg_t;

    // A retiring write targets index s; register $0 never matches.
    function automatic logic wr_hit(input logic rw, input logic [RW-1:0] wa,
                                    input logic [RW-1:0] s);
        return rw && (wa == s) && (s != '0);
    endfunction

endpackage

// File: rtl/idex_stage_if.sv
// ID-side inputs, forward sources, pipeline control and EX-side outputs of the ID/EX stage.
interface idex_stage_if;
    import idex_stage_pkg::*;

    logic           id_valid, stall, flush;
    logic [DW-1:0]  id_pc, id_rd1, id_rd2, id_imm;
    logic [RW-1:0]  id_rs, id_rt, id_wa;
    logic [OPW-1:0] id_aluop;
    logic           id_alusrc, id_regwrite, id_memread, id_memwrite;

    logic           exmem_regwrite, memwb_regwrite;
    logic [RW-1:0]  exmem_wa, memwb_wa;
    logic [DW-1:0]  exmem_result, memwb_wdata;

    logic           ex_valid, ex_regwrite, ex_memread, ex_memwrite, load_use;
    logic [DW-1:0]  ex_A, ex_B, ex_store_data, ex_pc;
    logic [OPW-1:0] ex_aluop;
    logic [RW-1:0]  ex_wa;

    modport slave (
        input  id_valid, stall, flush, id_pc, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_wa,
               id_aluop, id_alusrc, id_regwrite, id_memread, id_memwrite,
               exmem_regwrite, exmem_wa, exmem_result, memwb_regwrite, memwb_wa, memwb_wdata,
        output ex_valid, ex_A, ex_B, ex_aluop, ex_store_data, ex_wa, ex_pc,
               ex_regwrite, ex_memread, ex_memwrite, load_use
    );

    modport master (
        output id_valid, stall, flush, id_pc, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_wa,
               id_aluop, id_alusrc, id_regwrite, id_memread, id_memwrite,
               exmem_regwrite, exmem_wa, exmem_result, memwb_regwrite, memwb_wa, memwb_wdata,
        input  ex_valid, ex_A, ex_B, ex_aluop, ex_store_data, ex_wa, ex_pc,
               ex_regwrite, ex_memread, ex_memwrite, load_use
    );

endinterface

// File: rtl/idex_stage_fwd_mux.sv
// Per-operand forwarding mux: EX/MEM result beats MEM/WB data beats the held register value.
module fwd_mux
    import idex_stage_pkg::*;
(
    input  logic [RW-1:0] idx,
    input  logic [DW-1:0] held,
    input  logic          exmem_regwrite,
    input  logic [RW-1:0] exmem_wa,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_regwrite,
    input  logic [RW-1:0] memwb_wa,
    input  logic [DW-1:0] memwb_wdata,
    output logic [DW-1:0] value
);

    fwd_sel_e sel;

    always_comb begin
        sel = FWD_REG;
        if (wr_hit(exmem_regwrite, exmem_wa, idx))
            sel = FWD_EXMEM;
        else if (wr_hit(memwb_regwrite, memwb_wa, idx))
            sel = FWD_MEMWB;
    end

    always_comb begin
        value = held;
        case (sel)
            FWD_EXMEM: value = exmem_result;
            FWD_MEMWB: value = memwb_wdata;
            default:   value = held;
        endcase
    end

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with operand forwarding, ALUSrc selection, stall-time refresh of
// held operands and load-use hazard detection.
module idex_stage
    import idex_stage_pkg::*;
(
    input logic      clk,
    input logic      rstn,
    idex_stage_if.slave bus
);

    ex_reg_t       ex_q;
    ex_reg_t       id_word;
    logic [DW-1:0] fwd_rs, fwd_rt;

    always_comb begin
        id_word          = '0;
        id_word.valid    = 1'b1;
        id_word.regwrite = bus.id_regwrite;
        id_word.memread  = bus.id_memread;
        id_word.memwrite = bus.id_memwrite;
        id_word.alusrc   = bus.id_alusrc;
        id_word.aluop    = bus.id_aluop;
        id_word.rs       = bus.id_rs;
        id_word.rt       = bus.id_rt;
        id_word.wa       = bus.id_wa;
        id_word.pc       = bus.id_pc;
        id_word.rd1      = bus.id_rd1;
        id_word.rd2      = bus.id_rd2;
        id_word.imm      = bus.id_imm;
    end

    // While held, absorb MEM/WB writes to our sources; they retire before the stall releases.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_q <= '0;
        end else if (bus.flush) begin
            ex_q <= '0;
        end else if (bus.stall) begin
            if (wr_hit(bus.memwb_regwrite, bus.memwb_wa, ex_q.rs))
                ex_q.rd1 <= bus.memwb_wdata;
            if (wr_hit(bus.memwb_regwrite, bus.memwb_wa, ex_q.rt))
                ex_q.rd2 <= bus.memwb_wdata;
        end else if (bus.id_valid) begin
            ex_q <= id_word;
        end else begin
            ex_q <= '0;
        end
    end

    fwd_mux u_fwd_rs (
        .idx           (ex_q.rs),
        .held          (ex_q.rd1),
        .exmem_regwrite(bus.exmem_regwrite),
        .exmem_wa      (bus.exmem_wa),
        .exmem_result  (bus.exmem_result),
        .memwb_regwrite(bus.memwb_regwrite),
        .memwb_wa      (bus.memwb_wa),
        .memwb_wdata   (bus.memwb_wdata),
        .value         (fwd_rs)
    );

    fwd_mux u_fwd_rt (
        .idx           (ex_q.rt),
        .held          (ex_q.rd2),
        .exmem_regwrite(bus.exmem_regwrite),
        .exmem_wa      (bus.exmem_wa),
        .exmem_result  (bus.exmem_result),
        .memwb_regwrite(bus.memwb_regwrite),
        .memwb_wa      (bus.memwb_wa),
        .memwb_wdata   (bus.memwb_wdata),
        .value         (fwd_rt)
    );

    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_A          = fwd_rs;
    assign bus.ex_B          = ex_q.alusrc ? ex_q.imm : fwd_rt;
    assign bus.ex_store_data = fwd_rt;
    assign bus.ex_aluop      = ex_q.aluop;
    assign bus.ex_wa         = ex_q.wa;
    assign bus.ex_pc         = ex_q.pc;
    assign bus.ex_regwrite   = ex_q.valid & ex_q.regwrite;
    assign bus.ex_memread    = ex_q.valid & ex_q.memread;
    assign bus.ex_memwrite   = ex_q.valid & ex_q.memwrite;

    assign bus.load_use = ex_q.valid && ex_q.memread && (ex_q.wa != '0) && bus.id_valid &&
                          ((ex_q.wa == bus.id_rs) || ((ex_q.wa == bus.id_rt) && !bus.id_alusrc));

endmodule
